// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the programmable clock divider.
//   state_e : divider control states (IDLE, RUN, STOP)
//   MIN_DIV : smallest divisor that can be made active; smaller requests clamp
// ----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   localparam int unsigned MIN_DIV = 2;

endpackage : clk_div_pkg

// File: rtl/clk_div_period_cnt.sv
// ----------------------------------------------------------------------------
// clk_div_period_cnt
// Period counter for the clock divider: counts 0..N-1 and wraps to 0.
//   clkIn     : clock, rising edge
//   rstIn     : asynchronous active-high reset, clears the count
//   restartIn : synchronous restart, holds the count at 0
//   enIn      : count enable
//   divIn     : period length N (always >= 2)
//   cntOut    : current count
//   lastOut   : high while count == N-1
// ----------------------------------------------------------------------------
module clk_div_period_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             restartIn,
   input  logic             enIn,
   input  logic [CNT_W-1:0] divIn,
   output logic [CNT_W-1:0] cntOut,
   output logic             lastOut
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_c;

   // divIn is never below 2, so divIn-1 cannot underflow
   assign last_c = (cnt_q == (divIn - CNT_W'(1)));

   // Next count: restart or wrap to 0, otherwise advance when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (restartIn || (enIn && last_c)) begin
         cnt_d = '0;
      end else if (enIn) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cntOut  = cnt_q;
   assign lastOut = last_c;

endmodule : clk_div_period_cnt

// File: rtl/clk_div_prog.sv
// ----------------------------------------------------------------------------
// clk_div_prog
// Programmable clock divider with glitch-free divisor updates.
//   clkIn      : clock, rising edge
//   rstIn      : asynchronous active-high reset
//   enIn       : run enable (level)
//   divIn      : requested output period in clkIn cycles
//   divLoadIn  : one-cycle strobe capturing divIn as the pending divisor
//   clkOut     : divided clock, high for floor(N/2) cycles of each period
//   tickOut    : one-cycle pulse on each clkOut rising edge
//   loadAckOut : one-cycle pulse when the pending divisor becomes active
//   activeOut  : high while in RUN or STOP
// ----------------------------------------------------------------------------
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DIV_RST = 4
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             enIn,
   input  logic [CNT_W-1:0] divIn,
   input  logic             divLoadIn,
   output logic             clkOut,
   output logic             tickOut,
   output logic             loadAckOut,
   output logic             activeOut
);

   state_e           state_q;
   logic [CNT_W-1:0] div_act_q;
   logic [CNT_W-1:0] div_pend_q;
   logic [CNT_W-1:0] div_pend_d;
   logic             pend_q;
   logic             pend_d;
   logic             clk_q;
   logic             tick_q;
   logic             ack_q;
   logic             active_q;

   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             boundary_c;
   logic             apply_c;
   logic             clk_mid_c;
   logic [CNT_W-1:0] div_cap_c;
   logic [CNT_W-1:0] half_c;

   clk_div_period_cnt #(
      .CNT_W (CNT_W)
   ) u_period_cnt (
      .clkIn     (clkIn),
      .rstIn     (rstIn),
      .restartIn (state_q == IDLE),
      .enIn      (state_q != IDLE),
      .divIn     (div_act_q),
      .cntOut    (cnt),
      .lastOut   (last)
   );

   // Period boundary: RUN entry from IDLE, or a wrap that keeps running
   assign boundary_c = (state_q == IDLE) ? enIn : (enIn && last);
   assign apply_c    = boundary_c && pend_q;

   // Clock level for the next count inside the current period; only used
   // when not at N-1, so cnt+1 cannot overflow
   assign half_c    = div_act_q >> 1;
   assign clk_mid_c = ((cnt + CNT_W'(1)) < half_c);

   // Requests below the minimum divisor are clamped on capture
   assign div_cap_c = (divIn < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : divIn;

   // Pending divisor: newest strobe wins; a strobe coinciding with a
   // boundary is kept for the next boundary while the old value applies now
   always_comb begin
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      if (divLoadIn) begin
         div_pend_d = div_cap_c;
         pend_d     = 1'b1;
      end else if (apply_c) begin
         pend_d     = 1'b0;
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         div_pend_q <= CNT_W'(MIN_DIV);
         pend_q     <= 1'b0;
      end else begin
         div_pend_q <= div_pend_d;
         pend_q     <= pend_d;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q   <= IDLE;
         div_act_q <= CNT_W'(DIV_RST);
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
         ack_q     <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         if (boundary_c) begin
            // New period starts: count 0 is always in the high phase
            state_q  <= RUN;
            clk_q    <= 1'b1;
            tick_q   <= 1'b1;
            active_q <= 1'b1;
            if (pend_q) begin
               div_act_q <= div_pend_q;
               ack_q     <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  clk_q    <= 1'b0;
                  active_q <= 1'b0;
               end
               RUN, STOP: begin
                  if (last) begin
                     // Period finished with enable low: park
                     state_q  <= IDLE;
                     clk_q    <= 1'b0;
                     active_q <= 1'b0;
                  end else begin
                     if (!enIn) begin
                        state_q <= STOP;
                     end
                     clk_q <= clk_mid_c;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  clk_q    <= 1'b0;
                  active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign clkOut     = clk_q;
   assign tickOut    = tick_q;
   assign loadAckOut = ack_q;
   assign activeOut  = active_q;

endmodule : clk_div_prog

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the divisor and period counter.
REQ-002 Parameter DIV_RST, default 4, SHALL set the active divisor after reset; legal range is 2..2^CNT_W-1.
REQ-003 clkIn  input  1  SHALL be the clock; all logic is clocked on its rising edge.
REQ-004 rstIn  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 enIn  input  1  SHALL be the run enable; level-sensitive.
REQ-006 divIn  input  CNT_W  SHALL carry the requested output period in clkIn cycles.
REQ-007 divLoadIn  input  1  SHALL be a single-cycle strobe that captures divIn as the pending divisor.
REQ-008 clkOut  output  1  SHALL be the divided clock, driven directly from a register.
REQ-009 tickOut  output  1  SHALL pulse for one cycle, coincident with each clkOut rising edge.
REQ-010 loadAckOut  output  1  SHALL pulse for one cycle when a pending divisor becomes active.
REQ-011 activeOut  output  1  SHALL be high while the block is in RUN or STOP.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and STOP.
REQ-013 IDLE -> RUN SHALL occur on the first clkIn edge at which enIn=1. On that same edge clkOut SHALL go to 1, tickOut SHALL pulse and the period count SHALL be 0.
REQ-014 In RUN the period count SHALL run 0..N-1 and then wrap to 0, where N is the active divisor.
REQ-015 clkOut SHALL be 1 for counts 0..H-1 and 0 for counts H..N-1, where H = floor(N/2). Odd N therefore gives the longer low phase.
REQ-016 RUN -> STOP SHALL occur when enIn=0 is sampled. The current period SHALL still complete.
REQ-017 In STOP, at count N-1: if enIn=1, the state SHALL return to RUN with no gap; otherwise it SHALL go to IDLE with clkOut parked at 0.
REQ-018 A divLoadIn strobe SHALL write divIn into the pending register and set the pending flag. If a second strobe arrives before the pending value is applied, the latest value SHALL win.
REQ-019 The pending divisor SHALL become active only at a period boundary, meaning the wrap from N-1 to 0 or the IDLE -> RUN entry. loadAckOut SHALL pulse on that same edge and the pending flag SHALL clear.
REQ-020 If a strobe and a boundary occur in the same cycle, the strobed value SHALL be captured as pending and applied at the next boundary; the old pending value (if any) SHALL apply now.
REQ-021 A divisor value of 0 or 1 SHALL be clamped to 2 when it is captured.
REQ-022 In IDLE, a strobe SHALL be held pending and applied on RUN entry.
REQ-023 The output period SHALL never be truncated or glitched; every high and low phase SHALL have exactly its programmed length.
REQ-024 Divisor arithmetic SHALL be unsigned at CNT_W bits. H SHALL be computed by a right shift, with no overflow possible.

Reset
REQ-025 While rstIn=1, the block SHALL be in IDLE with clkOut=0, tickOut=0, loadAckOut=0, activeOut=0, count=0, active divisor=DIV_RST and pending flag=0.
REQ-026 Assertion of rstIn mid-period SHALL force these values immediately, regardless of clkIn.
REQ-027 After deassertion of rstIn, the first RUN entry SHALL follow REQ-013.

Structure
REQ-028 Package clk_div_pkg SHALL hold the state encoding typedef (IDLE, RUN, STOP) and the constant MIN_DIV=2.
REQ-029 The block SHALL contain one sub-module, clk_div_period_cnt: a CNT_W-bit counter with a synchronous restart that outputs count and a lastOut flag (count==N-1).
REQ-030 The top level SHALL hold the FSM, the pending/active divisor registers and the output registers.

Verification
REQ-031 DIV_RST=4, enIn=1 from reset release -> clkOut repeats 1,1,0,0; tickOut is high every 4th cycle, starting on the first enabled edge.
REQ-032 divIn=5 is strobed during the low phase of a period with N=4 -> that period completes as 1100; then 11000 repeats; loadAckOut pulses once, at the wrap.
REQ-033 divIn=3 then divIn=7 are strobed in consecutive cycles mid-period -> 7 applies at the next boundary (1110000); 3 is never used; a single loadAckOut pulse.
REQ-034 divIn=1 is strobed -> the clamp to 2 applies; clkOut toggles every cycle (1010...).
REQ-035 enIn drops at count 1 of N=6 -> counts 2..5 still complete (1 then 000); clkOut stays 0 and activeOut falls to 0. When enIn rises again, clkOut=1 and tickOut pulses on the next edge.
REQ-036 rstIn is pulsed mid-high phase between clkIn edges -> clkOut=0 immediately and the active divisor reverts to DIV_RST; normal restart follows per REQ-031.
